// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: data/id widths, write-enable
// encoding, register address width and the buffered muldiv result record.
package regfile_write_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int IID_W = 4;
  localparam int RF_AW = 5;

  typedef logic [XLEN-1:0]  UIntX;
  typedef logic [IID_W-1:0] IId;
  typedef logic [RF_AW-1:0] rf_addr_t;

  // Register-file write-enable encoding carried by the WB stage.
  localparam logic REN_X = 1'b0;
  localparam logic REN_S = 1'b1;

  localparam logic [0:0] ST_NORMAL   = 1'b0;
  localparam logic [0:0] ST_FORCE_MD = 1'b1;

  typedef struct packed {
    rf_addr_t addr;
    UIntX     data;
  } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Two-entry in-order buffer for muldiv results awaiting a register-file write port.
// The caller guarantees push only when not full and pop only when not empty.
module md_result_fifo
  import regfile_write_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  md_entry_t push_entry,
  input  logic      pop,
  output md_entry_t head,
  output logic [1:0] count
);

  md_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the WB stage and buffered
// muldiv results, forcing a muldiv write after STARVE_LIMIT consecutive denials.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  IId               wb_inst_id,
  input  logic             wb_wen,
  input  logic [RF_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_wdata,
  output logic             wb_stall,
  input  logic             md_valid,
  input  logic [RF_AW-1:0] md_addr,
  input  logic [XLEN-1:0]  md_wdata,
  output logic             md_ready,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [1:0]       md_count,
  output logic [0:0]       fsm_state
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [1:0]      FULL_COUNT = 2'(FIFO_DEPTH);

  logic [0:0]       state_q, state_nxt;
  logic [SW-1:0]    starve_q, starve_nxt;
  IId               saved_id;
  logic             id_seen;
  logic             wb_new;
  logic             sel_wb, sel_md;
  logic             md_push;
  md_entry_t        md_head;
  logic [RF_AW-1:0] sel_addr;
  UIntX             sel_data;

  // Ready is based on the registered occupancy only; a same-cycle pop gives no credit.
  assign md_ready  = md_count < FULL_COUNT;
  assign md_push   = md_valid && md_ready;
  assign wb_stall  = (state_q == ST_FORCE_MD);
  assign wb_new    = wb_valid && !wb_stall && (!id_seen || wb_inst_id != saved_id);
  assign fsm_state = state_q;

  md_result_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (md_push),
    .push_entry ({md_addr, md_wdata}),
    .pop        (sel_md),
    .head       (md_head),
    .count      (md_count)
  );

  always_comb begin
    sel_wb     = 1'b0;
    sel_md     = 1'b0;
    state_nxt  = state_q;
    starve_nxt = starve_q;
    case (state_q)
      ST_NORMAL: begin
        sel_wb = wb_new && (wb_wen == REN_S);
        sel_md = !sel_wb && (md_count != 2'd0);
        if (sel_md || md_count == 2'd0) starve_nxt = '0;
        else                            starve_nxt = starve_q + 1'b1;
        if (starve_nxt == STARVE_MAX) state_nxt = ST_FORCE_MD;
      end
      default: begin
        sel_md     = (md_count != 2'd0);
        starve_nxt = '0;
        state_nxt  = ST_NORMAL;
      end
    endcase
  end

  assign sel_addr = sel_wb ? wb_addr  : md_head.addr;
  assign sel_data = sel_wb ? wb_wdata : md_head.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      saved_id <= '0;
      id_seen  <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_nxt;
      starve_q <= starve_nxt;
      if (wb_valid && !wb_stall) begin
        saved_id <= wb_inst_id;
        id_seen  <= 1'b1;
      end
      // Writes to x0 are consumed but never reach the register file.
      rf_wen <= (sel_wb || sel_md) && (sel_addr != '0);
      if (sel_wb || sel_md) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Cycle-table bench for regfile_write_arbiter: per-cycle handshake checks plus a
// queue of expected register-file writes tagged with the cycle they must appear.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  wb_inst_id;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  md_count;
  logic [0:0]  fsm_state;

  regfile_write_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_inst_id (wb_inst_id),
    .wb_wen     (wb_wen),
    .wb_addr    (wb_addr),
    .wb_wdata   (wb_wdata),
    .wb_stall   (wb_stall),
    .md_valid   (md_valid),
    .md_addr    (md_addr),
    .md_wdata   (md_wdata),
    .md_ready   (md_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .md_count   (md_count),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [3:0]  id;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_stall;
    logic        e_ready;
    logic [1:0]  e_cnt;
    logic        e_w;
    logic [4:0]  e_a;
    logic [31:0] e_d;
  } vec_t;

  localparam int W = 53;
  logic [W-1:0] exp_q[$];
  logic [15:0]  cyc = 16'd0;
  int           n_cmp = 0;
  int           n_err = 0;
  vec_t         vecs [28];

  function automatic vec_t mk(input logic rst, input logic wv, input logic [3:0] id,
                              input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic es, input logic er, input logic [1:0] ec,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.wv = wv; v.id = id; v.wen = wen; v.wa = wa; v.wd = wd;
    v.mv = mv; v.ma = ma; v.md = md; v.e_stall = es; v.e_ready = er; v.e_cnt = ec;
    v.e_w = ew; v.e_a = ea; v.e_d = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compares the registered write port against the queue head due this cycle.
  task automatic check_rf();
    logic [W-1:0] f;
    logic         due;
    due = 1'b0;
    f   = '0;
    if (exp_q.size() > 0) begin
      f   = exp_q[0];
      due = (f[52:37] == cyc);
    end
    chk("rf_wen", rf_wen, due);
    if (due) begin
      f = exp_q.pop_front();
      chk("rf_waddr", rf_waddr, f[36:32]);
      chk("rf_wdata", rf_wdata, f[31:0]);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    check_rf();
    rst_n      = v.rst;
    wb_valid   = v.wv;
    wb_inst_id = v.id;
    wb_wen     = v.wen;
    wb_addr    = v.wa;
    wb_wdata   = v.wd;
    md_valid   = v.mv;
    md_addr    = v.ma;
    md_wdata   = v.md;
    #1;
    chk("wb_stall", wb_stall, v.e_stall);
    chk("md_ready", md_ready, v.e_ready);
    chk("md_count", md_count, v.e_cnt);
    if (v.e_w) exp_q.push_back({cyc + 16'd1, v.e_a, v.e_d});
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_inst_id = '0; wb_wen = 1'b0; wb_addr = '0;
    wb_wdata = '0; md_valid = 1'b0; md_addr = '0; md_wdata = '0;

    // New WB write, then the same id held for three cycles.
    vecs[0]  = mk(1, 1, 1, 1,  5, 'h11, 0,  0, 0,     0, 1, 0, 1,  5, 'h11);
    vecs[1]  = mk(1, 1, 1, 1,  5, 'h11, 0,  0, 0,     0, 1, 0, 0,  0, 0);
    vecs[2]  = mk(1, 1, 1, 1,  5, 'h11, 0,  0, 0,     0, 1, 0, 0,  0, 0);
    vecs[3]  = mk(1, 1, 1, 1,  5, 'h11, 0,  0, 0,     0, 1, 0, 0,  0, 0);
    // Single muldiv result with WB idle.
    vecs[4]  = mk(1, 0, 0, 0,  0, 0,    1,  7, 'hAB,  0, 1, 0, 0,  0, 0);
    vecs[5]  = mk(1, 0, 0, 0,  0, 0,    0,  0, 0,     0, 1, 1, 1,  7, 'hAB);
    vecs[6]  = mk(1, 0, 0, 0,  0, 0,    0,  0, 0,     0, 1, 0, 0,  0, 0);
    // Fill the buffer behind WB writes; third offer is refused until space frees.
    vecs[7]  = mk(1, 1, 2, 1,  3, 'h33, 1,  8, 'hC1,  0, 1, 0, 1,  3, 'h33);
    vecs[8]  = mk(1, 1, 3, 1,  4, 'h44, 1,  9, 'hC2,  0, 1, 1, 1,  4, 'h44);
    vecs[9]  = mk(1, 1, 4, 1,  6, 'h66, 1, 10, 'hC3,  0, 0, 2, 1,  6, 'h66);
    vecs[10] = mk(1, 0, 4, 0,  0, 0,    1, 10, 'hC3,  0, 0, 2, 1,  8, 'hC1);
    vecs[11] = mk(1, 0, 0, 0,  0, 0,    1, 10, 'hC3,  0, 1, 1, 1,  9, 'hC2);
    vecs[12] = mk(1, 0, 0, 0,  0, 0,    0,  0, 0,     0, 1, 1, 1, 10, 'hC3);
    vecs[13] = mk(1, 0, 0, 0,  0, 0,    0,  0, 0,     0, 1, 0, 0,  0, 0);
    // Starvation: four denials, one forced muldiv cycle, WB then resumes.
    vecs[14] = mk(1, 1, 5, 1, 13, 'h51, 1, 12, 'hD1,  0, 1, 0, 1, 13, 'h51);
    vecs[15] = mk(1, 1, 6, 1, 14, 'h61, 0,  0, 0,     0, 1, 1, 1, 14, 'h61);
    vecs[16] = mk(1, 1, 7, 1, 15, 'h71, 0,  0, 0,     0, 1, 1, 1, 15, 'h71);
    vecs[17] = mk(1, 1, 8, 1, 16, 'h81, 0,  0, 0,     0, 1, 1, 1, 16, 'h81);
    vecs[18] = mk(1, 1, 9, 1, 17, 'h91, 0,  0, 0,     0, 1, 1, 1, 17, 'h91);
    vecs[19] = mk(1, 1, 10, 1, 18, 'hA1, 0, 0, 0,     1, 1, 1, 1, 12, 'hD1);
    vecs[20] = mk(1, 1, 10, 1, 18, 'hA1, 0, 0, 0,     0, 1, 0, 1, 18, 'hA1);
    vecs[21] = mk(1, 1, 10, 1, 18, 'hA1, 0, 0, 0,     0, 1, 0, 0,  0, 0);
    // New id without register write enable.
    vecs[22] = mk(1, 1, 11, 0, 19, 'h99, 0, 0, 0,     0, 1, 0, 0,  0, 0);
    // Both sources target x0: consumed, nothing written.
    vecs[23] = mk(1, 1, 12, 1,  0, 'hEE, 1, 0, 'hEF,  0, 1, 0, 0,  0, 0);
    vecs[24] = mk(1, 0, 12, 0,  0, 0,    0, 0, 0,     0, 1, 1, 0,  0, 0);
    vecs[25] = mk(1, 0, 0, 0,  0, 0,    0,  0, 0,     0, 1, 0, 0,  0, 0);
    // Leave two results buffered for the reset sequence.
    vecs[26] = mk(1, 1, 13, 1, 20, 'hB0, 1, 21, 'hB1, 0, 1, 0, 1, 20, 'hB0);
    vecs[27] = mk(1, 1, 14, 1, 22, 'hB2, 1, 23, 'hB3, 0, 1, 1, 1, 22, 'hB2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_wen", rf_wen, 1'b0);
    chk("reset rf_waddr", rf_waddr, 5'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset md_count", md_count, 2'd0);
    chk("reset wb_stall", wb_stall, 1'b0);
    chk("reset md_ready", md_ready, 1'b1);

    for (int i = 0; i < 28; i++) step(vecs[i]);

    // Reset with two buffered results: they must be discarded.
    step(mk(0, 1, 14, 1, 22, 'hB2, 1, 24, 'hB4, 0, 0, 2, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("post-reset rf_waddr", rf_waddr, 5'd0);
    chk("post-reset rf_wdata", rf_wdata, 32'd0);
    chk("post-reset md_count", md_count, 2'd0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Id history is cleared too, so the previously seen id writes again.
    step(mk(1, 1, 14, 1, 25, 'hC5, 0, 0, 0, 0, 1, 0, 1, 25, 'hC5));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    check_rf();

    while (exp_q.size() > 0) begin
      logic [W-1:0] f;
      f = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing write: addr %0h data %0h never seen, required at cycle %0d",
               f[36:32], f[31:0], f[52:37]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
